// File: rtl/edge_frame_feeder_if.sv
// edge_frame_feeder_if: pixel stream in, core load burst and core reset out.
// Carries in_valid/in_pixel/in_ready (upstream stream), frame_done (collector pulse),
// pixel_out0..4/load_end/core_reset (to the edge-detection core).
// master: the side that drives the stream and frame_done; slave: the feeder.
interface edge_frame_feeder_if #(
  parameter int IN_WIDTH = 8,
  parameter int BIT_LENGTH = 5
);
  logic in_valid;
  logic [IN_WIDTH-1:0] in_pixel;
  logic in_ready;
  logic frame_done;
  logic [BIT_LENGTH-1:0] pixel_out0;
  logic [BIT_LENGTH-1:0] pixel_out1;
  logic [BIT_LENGTH-1:0] pixel_out2;
  logic [BIT_LENGTH-1:0] pixel_out3;
  logic [BIT_LENGTH-1:0] pixel_out4;
  logic load_end;
  logic core_reset;
  modport master (
    output in_valid, in_pixel, frame_done,
    input in_ready, pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4, load_end, core_reset
  );
  modport slave (
    input in_valid, in_pixel, frame_done,
    output in_ready, pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4, load_end, core_reset
  );
endinterface

// File: rtl/edge_frame_feeder.sv
// edge_frame_feeder: buffers one frame of quantized pixels and replays it as the core's load burst.
// Ports: clk; reset (asynchronous, active-low); bus (edge_frame_feeder_if.slave) with the
// in_valid/in_pixel/in_ready stream, frame_done from the collector, and pixel_out0..4,
// load_end, core_reset towards the core.
// FEEDER_QUANT_ROUND_EN: round-to-nearest quantization with saturation instead of truncation.
module edge_frame_feeder #(
  parameter int IMG_DIM = 20,
  parameter int BIT_LENGTH = 5,
  parameter int IN_WIDTH = 8,
  parameter int LANES = 5
) (
  input logic clk,
  input logic reset,
  edge_frame_feeder_if.slave bus
);
  localparam int BEATS = IMG_DIM * IMG_DIM / LANES;
  localparam int AW = $clog2(BEATS + 1);
  localparam int GW = $clog2(LANES);
  localparam int WW = LANES * BIT_LENGTH;
  typedef enum logic [1:0] {FILL, ARM, BURST} state_t;
  state_t state, state_d;
  logic [WW-1:0] mem [BEATS];
  logic [WW-BIT_LENGTH-1:0] gather;
  logic [WW-1:0] out_q, out_d;
  logic [AW-1:0] wr_addr, rd_addr, rd_sel;
  logic [GW-1:0] gcnt;
  logic [BIT_LENGTH-1:0] q;
  logic unused_lsbs;
  logic xfer, word_done, start, load, busy, busy_d, end_d;
`ifdef FEEDER_QUANT_ROUND_EN
  logic [IN_WIDTH:0] sum;
  assign sum = {1'b0, bus.in_pixel} + (IN_WIDTH + 1)'(1 << (IN_WIDTH - BIT_LENGTH - 1));
  assign q = sum[IN_WIDTH] ? '1 : sum[IN_WIDTH-1 -: BIT_LENGTH];
  assign unused_lsbs = ^sum[IN_WIDTH-BIT_LENGTH-1:0];
`else
  assign q = bus.in_pixel[IN_WIDTH-1 -: BIT_LENGTH];
  assign unused_lsbs = ^bus.in_pixel[IN_WIDTH-BIT_LENGTH-1:0];
`endif
  // in_ready is only ever high in FILL, so a transfer implies FILL and the buffer is idle for reads
  assign xfer = bus.in_valid && bus.in_ready;
  assign word_done = xfer && gcnt == GW'(LANES - 1);
  assign start = state == ARM && !busy;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FILL;
    else state <= state_d;
  always_comb
    state_d = (word_done && wr_addr == AW'(BEATS - 1)) ? ARM :
              start ? BURST :
              (state == BURST && rd_addr == AW'(BEATS)) ? FILL : state;
  // rd_addr is the word to load at the next edge; word 0 is loaded on the ARM->BURST edge
  always_comb begin
    rd_sel = state == ARM ? '0 : rd_addr;
    load = start || (state == BURST && rd_addr != AW'(BEATS));
    out_d = load ? mem[rd_sel] : '0;
    end_d = load && rd_sel == AW'(BEATS - 1);
    busy_d = start || (busy && !bus.frame_done);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_addr <= '0;
      rd_addr <= '0;
      gcnt <= '0;
      gather <= '0;
      busy <= 1'b0;
      out_q <= '0;
      bus.load_end <= 1'b0;
      bus.core_reset <= 1'b1;
      bus.in_ready <= 1'b0;
    end else begin
      busy <= busy_d;
      bus.core_reset <= !busy_d;
      bus.in_ready <= state_d == FILL;
      out_q <= out_d;
      bus.load_end <= end_d;
      rd_addr <= load ? rd_sel + 1'b1 : '0;
      if (xfer) begin
        gather <= {q, gather[WW-BIT_LENGTH-1:BIT_LENGTH]};
        gcnt <= word_done ? '0 : gcnt + 1'b1;
      end
      if (word_done) wr_addr <= wr_addr == AW'(BEATS - 1) ? '0 : wr_addr + 1'b1;
    end
  // oldest pixel of the gather register sits in the lowest lane
  always_ff @(posedge clk)
    if (word_done) mem[wr_addr] <= {q, gather};
  assign bus.pixel_out0 = out_q[0*BIT_LENGTH +: BIT_LENGTH];
  assign bus.pixel_out1 = out_q[1*BIT_LENGTH +: BIT_LENGTH];
  assign bus.pixel_out2 = out_q[2*BIT_LENGTH +: BIT_LENGTH];
  assign bus.pixel_out3 = out_q[3*BIT_LENGTH +: BIT_LENGTH];
  assign bus.pixel_out4 = out_q[4*BIT_LENGTH +: BIT_LENGTH];
endmodule
